// File: rtl/cv32e40p_wb_pkg.sv
// cv32e40p_wb_pkg
// Shared types and constants for the write-back arbiter slice.
//   wb_entry_t : one buffered EX write (live bit, destination, data)
//   REG_X0     : architectural zero register index
package cv32e40p_wb_pkg;

    typedef struct packed {
        logic        live;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/cv32e40p_wb_match.sv
// cv32e40p_wb_match
// Finds the youngest pending write to one register-file read address.
// Ports:
//   entries_i  : buffered EX writes ordered by age, index 0 = oldest
//   out_we_i / out_addr_i / out_data_i : write-port output register
//   raddr_i    : read address to look up (x0 never matches)
//   hit_o      : a pending write targets raddr_i
//   data_o     : data of the youngest such write (0 when no hit)
module cv32e40p_wb_match
    import cv32e40p_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  wb_entry_t [DEPTH-1:0] entries_i,
    input  logic                  out_we_i,
    input  logic [4:0]            out_addr_i,
    input  logic [31:0]           out_data_i,
    input  logic [4:0]            raddr_i,
    output logic                  hit_o,
    output logic [31:0]           data_o
);

    // Oldest source first; each later hit overrides, so the youngest wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        if (raddr_i != REG_X0) begin
            if (out_we_i && (out_addr_i == raddr_i)) begin
                hit_o  = 1'b1;
                data_o = out_data_i;
            end
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (entries_i[k].live && (entries_i[k].addr == raddr_i)) begin
                    hit_o  = 1'b1;
                    data_o = entries_i[k].data;
                end
            end
        end
    end

endmodule

// File: rtl/cv32e40p_wb_arbiter.sv
// cv32e40p_wb_arbiter
// Merges EX results and LSU load responses onto the single register-file
// write port. LSU always wins; losing EX results wait in a DEPTH-entry
// in-order FIFO. Reports RAW hazards on three read ports for writes the
// block holds but has not committed.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   ex_valid_i/ex_ready_o           : EX handshake, ex_waddr_i/ex_wdata_i
//   lsu_valid_i/lsu_waddr_i/lsu_wdata_i : load response (no back-pressure)
//   we_a_o/waddr_a_o/wdata_a_o      : registered write port
//   raddr_{a,b,c}_i                 : decode read addresses
//   hazard_{a,b,c}_o                : operand must stall
//   fwd_valid_{a,b,c}_o / fwd_data_{a,b,c}_o : forwarding (CV32E40P_WB_FWD_EN)
// Build option: define CV32E40P_WB_FWD_EN to forward pending data instead
// of raising hazards; undefined, the fwd outputs are tied to 0.
module cv32e40p_wb_arbiter
    import cv32e40p_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        we_a_o,
    output logic [4:0]  waddr_a_o,
    output logic [31:0] wdata_a_o,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    input  logic [4:0]  raddr_c_i,
    output logic        hazard_a_o,
    output logic        hazard_b_o,
    output logic        hazard_c_o,
    output logic        fwd_valid_a_o,
    output logic        fwd_valid_b_o,
    output logic        fwd_valid_c_o,
    output logic [31:0] fwd_data_a_o,
    output logic [31:0] fwd_data_b_o,
    output logic [31:0] fwd_data_c_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    wb_entry_t        fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             we_q;
    logic [4:0]       waddr_q;
    logic [31:0]      wdata_q;

    logic        ex_live, kill, push, pop, issue, issue_we;
    logic [4:0]  issue_addr;
    logic [31:0] issue_data;
    wb_entry_t   push_entry, head;

    assign ex_ready_o = (count_q != CNT_FULL);
    assign ex_live    = ex_valid_i && ex_ready_o && (ex_waddr_i != REG_X0);
    assign kill       = lsu_valid_i && (lsu_waddr_i != REG_X0);
    assign head       = fifo_q[rd_ptr_q];

    always_comb begin
        push_entry.live = !(kill && (ex_waddr_i == lsu_waddr_i));
        push_entry.addr = ex_waddr_i;
        push_entry.data = ex_wdata_i;
    end

    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        issue      = 1'b0;
        issue_we   = 1'b0;
        issue_addr = '0;
        issue_data = '0;
        if (lsu_valid_i) begin
            push       = ex_live;
            issue      = 1'b1;
            issue_we   = (lsu_waddr_i != REG_X0);
            issue_addr = lsu_waddr_i;
            issue_data = lsu_wdata_i;
        end else if (count_q != '0) begin
            push       = ex_live;
            pop        = 1'b1;
            issue      = 1'b1;
            issue_we   = head.live;
            issue_addr = head.addr;
            issue_data = head.data;
        end else if (ex_live) begin
            issue      = 1'b1;
            issue_we   = 1'b1;
            issue_addr = ex_waddr_i;
            issue_data = ex_wdata_i;
        end
    end

    // Popped slots have their live bit cleared so that "live" alone marks a
    // pending buffered write; the hazard search then needs no occupancy mask.
    // Push never targets the popped slot: that would need a full FIFO, which
    // blocks EX acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pop) begin
                fifo_q[rd_ptr_q].live <= 1'b0;
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (kill) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (fifo_q[i].addr == lsu_waddr_i) begin
                        fifo_q[i].live <= 1'b0;
                    end
                end
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= push_entry;
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= issue_we;
            if (issue) begin
                waddr_q <= issue_addr;
                wdata_q <= issue_data;
            end
        end
    end

    assign we_a_o    = we_q;
    assign waddr_a_o = waddr_q;
    assign wdata_a_o = wdata_q;

    // Rotate the circular buffer into age order (index 0 = head/oldest).
    wb_entry_t [DEPTH-1:0] ordered;
    always_comb begin
        ordered = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            int unsigned idx;
            idx = k + 32'(rd_ptr_q);
            if (idx >= DEPTH) begin
                idx = idx - DEPTH;
            end
            ordered[k] = fifo_q[idx];
        end
    end

    logic [2:0][4:0]  raddr;
    logic [2:0]       hit;
    logic [2:0][31:0] hit_data;

    assign raddr[0] = raddr_a_i;
    assign raddr[1] = raddr_b_i;
    assign raddr[2] = raddr_c_i;

    for (genvar p = 0; p < 3; p++) begin : g_match
        cv32e40p_wb_match #(
            .DEPTH (DEPTH)
        ) u_match (
            .entries_i  (ordered),
            .out_we_i   (we_q),
            .out_addr_i (waddr_q),
            .out_data_i (wdata_q),
            .raddr_i    (raddr[p]),
            .hit_o      (hit[p]),
            .data_o     (hit_data[p])
        );
    end

`ifdef CV32E40P_WB_FWD_EN
    assign hazard_a_o    = 1'b0;
    assign hazard_b_o    = 1'b0;
    assign hazard_c_o    = 1'b0;
    assign fwd_valid_a_o = hit[0];
    assign fwd_valid_b_o = hit[1];
    assign fwd_valid_c_o = hit[2];
    assign fwd_data_a_o  = hit_data[0];
    assign fwd_data_b_o  = hit_data[1];
    assign fwd_data_c_o  = hit_data[2];
`else
    logic unused_fwd_data;
    assign unused_fwd_data = ^hit_data;
    assign hazard_a_o    = hit[0];
    assign hazard_b_o    = hit[1];
    assign hazard_c_o    = hit[2];
    assign fwd_valid_a_o = 1'b0;
    assign fwd_valid_b_o = 1'b0;
    assign fwd_valid_c_o = 1'b0;
    assign fwd_data_a_o  = '0;
    assign fwd_data_b_o  = '0;
    assign fwd_data_c_o  = '0;
`endif

endmodule
